tdm_demux4: RTL
===============

Name: tdm_demux4

Overview:
- Receive end of a 4-channel time-division link. The transmit end is a 4:1 mux with a rotating select.
- Takes a 1-bit serial stream, in which each frame carries one bit per channel in slot order a, b, c, d, with frame sync on slot 0.
- Steers each bit to its channel and deserialises DATA_W frames into one parallel word per channel.
- Sits between the serial link pins and the per-channel consumers.

Parameters:
- DATA_W, 8, bits per channel word. Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  din and fsync are sampled only when this is 1.
- fsync  input  1  high with the slot-0 (channel a) bit of every frame.
- out_a  output  DATA_W  channel a word, MSB first on the link.
- out_b  output  DATA_W  channel b word.
- out_c  output  DATA_W  channel c word.
- out_d  output  DATA_W  channel d word.
- out_valid  output  1  one-cycle pulse when out_a..out_d update.
- locked  output  1  1 while in LOCKED state.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- One clock. Reset is synchronous, active-low; rst_n is sampled on the rising edge of clk.
- Reset values:
  - out_a..out_d = 0, out_valid = 0, locked = 0, sync_err = 0.
  - state = HUNT, slot = 0, frame_cnt = 0, shift registers = 0.
  - A reset mid-word discards all partial data.
- Internal state:
  - 2-bit slot counter (0..3, wraps 3->0).
  - frame_cnt, 0..DATA_W-1.
  - Four DATA_W shift registers, shifting left with the new bit entering the LSB.
- din_valid = 0: no state change. out_valid and sync_err fall to 0 (pulses only).
- State HUNT, with din_valid = 1:
  - fsync = 0: bit discarded.
  - fsync = 1: bit shifted into reg_a, slot becomes 1, frame_cnt becomes 0, go to LOCKED.
- State LOCKED, with din_valid = 1:
  - slot = 0 and fsync = 1: normal. Shift into reg_a, slot becomes 1.
  - slot != 0 and fsync = 0: normal. Shift into the register selected by slot (1 = b, 2 = c, 3 = d); slot increments.
  - slot != 0 and fsync = 1 (early sync): sync_err pulses.
    - Clear all shift registers and frame_cnt.
    - Treat the bit as slot 0 of a new frame: it goes into reg_a, slot becomes 1.
    - Stay in LOCKED.
  - slot = 0 and fsync = 0 (missing sync): sync_err pulses.
    - Discard the bit, clear the shift registers.
    - slot = 0, frame_cnt = 0, go to HUNT.
- Frame completion: the slot-3 bit is accepted, slot wraps to 0.
  - If frame_cnt = DATA_W-1: on the same edge, out_a..out_d load the completed registers (including the bit just received), out_valid = 1 for one cycle, frame_cnt becomes 0.
  - Otherwise frame_cnt increments.
- Latency: out_valid is visible in the cycle after the final slot-3 bit is sampled.
- out_a..out_d hold their value until the next word completes. They are never partially updated, and they are not cleared by sync_err.
- Back-to-back frames with din_valid held at 1 are supported with no gap cycles. A new word can begin on the cycle out_valid is high.
- Channel-to-slot mapping matches the transmit mux: slot 0 = a (select 00), slot 1 = b (01), slot 2 = c (10), slot 3 = d (11).

Decomposition:
- Shared package tdm_pkg:
  - NUM_CH = 4 and SLOT_W = 2.
  - State encoding HUNT = 1'b0, LOCKED = 1'b1.
  - Slot constants SLOT_A..SLOT_D.
  - The companion transmitter uses the same package.
- One natural sub-module: tdm_chan_shift, a DATA_W shift register with enable and clear, instantiated four times. Its enable is the slot decode (1-of-4 demux) ANDed with din_valid.
- The FSM, slot counter, frame counter and output registers stay in the top level.

Test Plan:
- Reset, then 8 clean frames (DATA_W = 8) sending a = 8'hA5, b = 8'h3C, c = 8'hFF, d = 8'h01, din_valid held at 1 -> locked rises after the first fsync. One cycle after the 32nd bit, out_valid pulses once with out_a = A5, out_b = 3C, out_c = FF, out_d = 01.
- Same words with din_valid toggling 1,0,1,0 throughout -> identical outputs, out_valid still a single pulse, no sync_err.
- Two consecutive words (A5/3C/FF/01, then 5A/C3/00/80) -> two out_valid pulses exactly 32 valid cycles apart. Outputs hold the first word until the second pulse.
- fsync asserted at slot 2 of frame 3 -> sync_err pulses once and locked stays 1. The next out_valid arrives 32 valid bits after the offending bit, carrying the word that started there.
- fsync missing at slot 0 -> sync_err pulses and locked goes to 0. Bits are ignored until the next fsync; the prior out_a..out_d are unchanged.
- rst_n low for 1 cycle in the middle of frame 5 -> all outputs are 0 and locked = 0. A full new 32-bit sequence yields the correct words with no residue from the aborted word.

Source files
------------

// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_pkg
// Description : Constants shared by the 4-channel TDM demux and its transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [SLOT_W-1:0] SLOT_A = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT_B = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT_C = 2'd2;
    localparam logic [SLOT_W-1:0] SLOT_D = 2'd3;

endpackage
`default_nettype wire

// File: rtl/tdm_chan_shift.sv
`default_nettype none
// ============================================================================
// Module      : tdm_chan_shift
// Description : Per-channel left shift register, new bit enters the LSB.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_chan_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_din,
    output logic [DATA_W-1:0] o_q,
    output logic [DATA_W-1:0] o_q_next
);

    logic [DATA_W-1:0] r_q;

    assign o_q      = r_q;
    assign o_q_next = {r_q[DATA_W-2:0], i_din};

    // Clear together with enable restarts the word with the current bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= i_en ? {{(DATA_W-1){1'b0}}, i_din} : '0;
        end else if (i_en) begin
            r_q <= o_q_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux4
// Description : 4-channel TDM receiver: frame lock, slot steering, deserialise.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_valid,
    input  logic              fsync,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic [DATA_W-1:0] out_d,
    output logic              out_valid,
    output logic              locked,
    output logic              sync_err
);

    localparam int                 c_CNT_W    = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);

    logic [0:0]         r_state;
    logic [SLOT_W-1:0]  r_slot;
    logic [c_CNT_W-1:0] r_frame_cnt;
    logic [DATA_W-1:0]  r_out_a, r_out_b, r_out_c, r_out_d;
    logic               r_out_valid;
    logic               r_sync_err;

    logic               w_early;
    logic               w_missing;
    logic               w_accept;
    logic               w_clr;
    logic               w_last;
    logic               w_done;
    logic [SLOT_W-1:0]  w_eff_slot;
    logic [DATA_W-1:0]  w_q      [NUM_CH];
    logic [DATA_W-1:0]  w_q_next [NUM_CH];
    logic [DATA_W-1:0]  w_word   [NUM_CH];

    assign w_early    = din_valid && (r_state == LOCKED) && (r_slot != SLOT_A) && fsync;
    assign w_missing  = din_valid && (r_state == LOCKED) && (r_slot == SLOT_A) && !fsync;
    assign w_accept   = din_valid && ((r_state == LOCKED) ? !w_missing : fsync);
    // An accepted sync bit always lands in channel a, whatever the slot counter says.
    assign w_eff_slot = ((r_state == HUNT) || w_early) ? SLOT_A : r_slot;
    assign w_clr      = w_early || w_missing;
    assign w_last     = w_accept && (w_eff_slot == SLOT_D);
    assign w_done     = w_last && (r_frame_cnt == c_CNT_LAST);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        tdm_chan_shift #(
            .DATA_W (DATA_W)
        ) u_shift (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (w_accept && (w_eff_slot == SLOT_W'(gi))),
            .i_clr    (w_clr),
            .i_din    (din),
            .o_q      (w_q[gi]),
            .o_q_next (w_q_next[gi])
        );
        // Channel d completes on the same edge its last bit arrives.
        assign w_word[gi] = (gi == NUM_CH - 1) ? w_q_next[gi] : w_q[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= HUNT;
            r_slot      <= SLOT_A;
            r_frame_cnt <= '0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_c     <= '0;
            r_out_d     <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_out_valid <= w_done;
            r_sync_err  <= w_clr;
            if (w_missing) begin
                r_state     <= HUNT;
                r_slot      <= SLOT_A;
                r_frame_cnt <= '0;
            end else if (w_accept) begin
                r_state <= LOCKED;
                r_slot  <= w_eff_slot + SLOT_W'(1);
                if ((r_state == HUNT) || w_early || w_done) begin
                    r_frame_cnt <= '0;
                end else if (w_last) begin
                    r_frame_cnt <= r_frame_cnt + c_CNT_W'(1);
                end
                if (w_done) begin
                    r_out_a <= w_word[0];
                    r_out_b <= w_word[1];
                    r_out_c <= w_word[2];
                    r_out_d <= w_word[3];
                end
            end
        end
    end

    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_c     = r_out_c;
    assign out_d     = r_out_d;
    assign out_valid = r_out_valid;
    assign locked    = r_state;
    assign sync_err  = r_sync_err;

endmodule
`default_nettype wire
